// File: rtl/mul_seq_if.sv
// Operand/result bundle for the sequential Booth multiplier.
// master drives the request side; slave is the multiplier itself.
interface mul_seq_if #(
  parameter int W = 16
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/mul_seq.sv
// Sequential signed radix-2 Booth multiplier: one W-bit x W-bit product per start.
// Latency W cycles from start edge to done; start is ignored while busy (no queueing).
module mul_seq #(
  parameter int W = 16
) (
  input  logic      clk,
  input  logic      rstn,
  mul_seq_if.slave  bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     m_q, m_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     q_q, q_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   p_q, p_d;
  logic [W:0]       sum;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    sum     = {acc_q[W-1], acc_q};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          m_d     = bus.a;
          acc_d   = '0;
          q_d     = bus.b;
          q1_d    = 1'b0;
          cnt_d   = CW'(W);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // One bit of headroom keeps A - M exact when M is the most negative value.
        case ({q_q[0], q1_q})
          2'b01:   sum = {acc_q[W-1], acc_q} + {m_q[W-1], m_q};
          2'b10:   sum = {acc_q[W-1], acc_q} - {m_q[W-1], m_q};
          default: sum = {acc_q[W-1], acc_q};
        endcase
        acc_d = sum[W:1];
        q_d   = {sum[0], q_q[W-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          p_d     = {sum[W:1], sum[0], q_q[W-1:1]};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.p    = p_q;

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: arithmetic reference model feeds a scoreboard queue,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_seq;

  localparam int W  = 16;
  localparam int PW = 2 * W;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mul_seq_if #(.W(W)) bus ();
  mul_seq #(.W(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic [PW-1:0] p;
    int            cyc;
  } exp_t;

  exp_t           exp_q[$];
  exp_t           e_push, e_pop;
  int             tests  = 0;
  int             fails  = 0;
  int             cyc    = 0;
  int             m_busy = 0;
  int             dones  = 0;
  logic [PW-1:0]  last_p = '0;
  longint         acc_exp = 0;
  longint         acc_dut = 0;
  logic signed [PW-1:0] sa, sbv, prod;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag(input string name, input string msg);
    tests++;
    fails++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  // Reference model: an idle multiplier accepts start and owes the exact product W cycles later.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      foreach (exp_q[i]) acc_exp -= longint'($signed(exp_q[i].p));
      exp_q.delete();
      m_busy = 0;
      last_p = '0;
    end else begin
      cyc++;
      if (m_busy == 0 && bus.start === 1'b1) begin
        sa       = $signed(bus.a);
        sbv      = $signed(bus.b);
        prod     = sa * sbv;
        e_push.p   = prod;
        e_push.cyc = cyc + W;
        exp_q.push_back(e_push);
        acc_exp += longint'(prod);
        m_busy   = W + 1;
      end else if (m_busy > 0) begin
        m_busy--;
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("busy", {63'd0, bus.busy}, {63'd0, (m_busy > 0)});
      if (bus.done === 1'b1) begin
        dones++;
        acc_dut += longint'($signed(bus.p));
        if (exp_q.size() == 0) begin
          flag("unexpected_done", $sformatf("done with p=%h but nothing outstanding", bus.p));
        end else begin
          e_pop = exp_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e_pop.cyc));
          chk("product", 64'(bus.p), 64'(e_pop.p));
          last_p = e_pop.p;
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e_pop = exp_q.pop_front();
          flag("missing_done", $sformatf("no done for expected p=%h due cycle %0d", e_pop.p, e_pop.cyc));
        end
        chk("p_hold", 64'(bus.p), 64'(last_p));
      end
    end
  end

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] req);
    int n;
    int bc;
    n  = 0;
    bc = 0;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && n < W + 8) begin
      if (bus.busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) begin
      flag("timeout", $sformatf("no done within %0d cycles", W + 8));
    end else begin
      if (bus.busy === 1'b1) bc++;
      chk("latency", 64'(n), 64'(W));
      chk("p_const", 64'(bus.p), 64'(req));
      chk("busy_cycles", 64'(bc), 64'(W + 1));
    end
    @(negedge clk);
    chk("done_width", {63'd0, bus.done}, 64'd0);
    chk("busy_after", {63'd0, bus.busy}, 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_p", 64'(bus.p), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    run_one(16'd3, 16'd5, 32'h0000000F);
    run_one(16'hFFF9, 16'd6, 32'hFFFFFFD6);
    run_one(16'd6, 16'hFFF9, 32'hFFFFFFD6);
    run_one(16'h8000, 16'h8000, 32'h40000000);
    run_one(16'h7FFF, 16'h8000, 32'hC0008000);
    run_one(16'h0000, 16'h8000, 32'h00000000);

    // start pulses during RUN and during DONE must be dropped
    bus.a = 16'd2; bus.b = 16'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.a = 16'd9; bus.b = 16'd9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < W + 4 && bus.done !== 1'b1; i++) @(negedge clk);
    chk("ignored_start_p", 64'(bus.p), 64'h4);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    d0 = dones;
    repeat (W + 4) @(negedge clk);
    chk("no_second_done", 64'(dones - d0), 64'd0);

    // asynchronous reset mid-RUN discards the product
    bus.a = 16'd100; bus.b = 16'd100; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    chk("arst_done", {63'd0, bus.done}, 64'd0);
    chk("arst_p", 64'(bus.p), 64'd0);
    @(posedge clk);
    #2 rstn = 1'b1;
    d0 = dones;
    repeat (W + 4) @(negedge clk);
    chk("no_done_after_rst", 64'(dones - d0), 64'd0);
    run_one(16'hFFFF, 16'hFFFF, 32'h00000001);

    // start held high: back-to-back products feeding a running sum
    acc_dut = 0;
    acc_exp = 0;
    d0 = dones;
    bus.a = 16'd1; bus.b = 16'd1; bus.start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) bus.b = bus.b + 16'd1;
    end
    bus.start = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("held_count", 64'(dones - d0), 64'd4);
    chk("held_sum_const", 64'(acc_dut), 64'd10);
    chk("held_sum_model", 64'(acc_dut), 64'(acc_exp));

    // random traffic, including start pulses while busy
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.a     = rnd_op();
      bus.b     = rnd_op();
    end
    bus.start = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Sequential signed (two's-complement) radix-2 Booth multiplier, one product per start.
- Upstream stage of the FIR datapath: turns sample x coefficient into a 2W-bit product that feeds the 32-bit accumulate adder.
- done is a one-cycle strobe wired directly to the adder's register-enable (r); p is the adder's operand.
- Area-lean: one add/subtract per cycle, W iterations per product.

Parameters:
W, 16, operand width in bits; product width is 2W (32 at default, matching the adder).

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
a  input  W  multiplicand, signed; sampled with start
b  input  W  multiplier, signed; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; p valid and newly updated
p  output  2W  signed product; held until next done

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, busy=0, done=0, p=0, counter=0, internal registers=0. Takes effect immediately, including mid-RUN. The in-flight product is discarded; no done is issued.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE, start=1 at edge k:
  - M<=a; A<=0; Q<=b; q_1<=0; cnt<=W; state<=RUN.
  - a/b are don't-care at all other times.
- RUN, each edge, one Booth step on {Q[0],q_1}:
  - 01: A<=A+M.
  - 10: A<=A-M.
  - 00/11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_1} by 1; MSB of A is replicated.
  - Add/sub is W+1 bits wide (sign-extend A and M) so W=16 with M=-32768 does not overflow.
  - cnt decrements.
  - On the edge where cnt goes 1->0 (edge k+W): p<={A,Q} of the shifted result; state<=DONE.
- DONE:
  - done=1, busy=1 for exactly one cycle.
  - Next edge: state<=IDLE, done=0.
- Latency and throughput:
  - done is high in the cycle following edge k+W; p is valid from that same cycle.
  - Minimum start-to-start spacing is W+2 cycles.
- start while busy=1 (RUN or DONE): ignored, not queued. Operands and p are unaffected.
- start held high continuously: a new product begins at the first edge in IDLE.
- p changes only on entry to DONE and on reset. It remains stable between done pulses, so the downstream adder may sample it on either clock edge of the done cycle.
- Outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- Result is exact for all signed W-bit pairs, including most-negative x most-negative.

Test Plan:
- Reset then a=3, b=5, start 1 cycle -> done pulse exactly 16 cycles after start edge, p=0x0000000F, busy high 17 cycles, done high 1 cycle.
- a=-7 (0xFFF9), b=6 -> p=0xFFFFFFD6 (-42). Then a=6, b=-7 -> same p.
- a=0x8000, b=0x8000 -> p=0x40000000. a=0x7FFF, b=0x8000 -> p=0xC0008000. a=0, b=0x8000 -> p=0.
- Start a=2, b=2. Pulse start with a=9, b=9 at cycle 5 (RUN) and during the DONE cycle -> single done, p=0x00000004, no second product.
- Start a=100, b=100. Drop rstn at cycle 8 for 1 cycle (asynchronously, between edges) -> busy/done/p go 0 immediately, no done afterward. Restart a=-1, b=-1 -> p=0x00000001.
- start held high 60 cycles with a=1, b=i incrementing per product -> done every 18 cycles, p=i sequence. p is stable between pulses and feeds the adder, which accumulates the correct running sum.
